// File: rtl/message_scroller.sv
// Scrolling message driver for multiplexed 7-segment displays: debounced next/prev
// buttons and an auto-scroll timer move a NUM_DIGITS-wide window over a writable buffer.
module message_scroller #(
    parameter int NUM_DIGITS      = 4,
    parameter int MSG_DEPTH       = 16,
    parameter int CHAR_W          = 4,
    parameter int DEBOUNCE_CYCLES = 65536,
    parameter int REFRESH_CYCLES  = 1024,
    parameter int AUTO_CYCLES     = 2 ** 22,
    localparam int AW = (MSG_DEPTH > 1) ? $clog2(MSG_DEPTH) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  btn_next,
    input  logic                  btn_prev,
    input  logic                  auto_en,
    input  logic                  wr_en,
    input  logic [AW-1:0]         wr_addr,
    input  logic [CHAR_W-1:0]     wr_data,
    output logic [NUM_DIGITS-1:0] an,
    output logic [CHAR_W-1:0]     digit_char,
    output logic [AW-1:0]         pointer,
    output logic                  step
);

    localparam int DW  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int DBW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int RW  = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
    localparam int TW  = (AUTO_CYCLES > 1) ? $clog2(AUTO_CYCLES) : 1;

    localparam logic [AW-1:0]  PTR_LAST  = AW'(MSG_DEPTH - 1);
    localparam logic [AW:0]    DEPTH_W   = (AW + 1)'(MSG_DEPTH);
    localparam logic [AW:0]    OFS_BASE  = (AW + 1)'(NUM_DIGITS - 1);
    localparam logic [DW-1:0]  DIG_LAST  = DW'(NUM_DIGITS - 1);
    localparam logic [DBW-1:0] DB_LAST   = DBW'(DEBOUNCE_CYCLES - 1);
    localparam logic [RW-1:0]  REF_LAST  = RW'(REFRESH_CYCLES - 1);
    localparam logic [TW-1:0]  AUTO_LAST = TW'(AUTO_CYCLES - 1);

    // Bit order of the synchroniser chain: {auto, prev, next}
    logic [2:0]            sync1_q, sync2_q;
    logic [1:0]            accepted_q, press_q;
    logic [DBW-1:0]        db_cnt_q [2];
    logic [TW-1:0]         auto_cnt_q;
    logic [AW-1:0]         pointer_q, ptr_d, ptr_inc, ptr_dec;
    logic                  step_q, step_d;
    logic [RW-1:0]         refresh_q;
    logic [DW-1:0]         digit_idx_q;
    logic [CHAR_W-1:0]     buffer_q [MSG_DEPTH];
    logic [AW:0]           rd_sum;
    logic [AW-1:0]         rd_idx;
    logic [NUM_DIGITS-1:0] an_q, an_d, digit_onehot;
    logic [CHAR_W-1:0]     char_q;
    logic                  press_next, press_prev, auto_tick, take_tick, btn_step;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= {auto_en, btn_prev, btn_next};
            sync2_q <= sync1_q;
        end
    end

    // A level that differs from the accepted one must stay put for DEBOUNCE_CYCLES
    // cycles; only a newly accepted 1 produces a press pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            accepted_q <= '0;
            press_q    <= '0;
            for (int b = 0; b < 2; b++) db_cnt_q[b] <= '0;
        end else begin
            for (int b = 0; b < 2; b++) begin
                press_q[b] <= 1'b0;
                if (sync2_q[b] == accepted_q[b]) begin
                    db_cnt_q[b] <= '0;
                end else if (db_cnt_q[b] == DB_LAST) begin
                    db_cnt_q[b]   <= '0;
                    accepted_q[b] <= sync2_q[b];
                    press_q[b]    <= sync2_q[b];
                end else begin
                    db_cnt_q[b] <= db_cnt_q[b] + 1'b1;
                end
            end
        end
    end

    assign press_next = press_q[0] & ~press_q[1];
    assign press_prev = press_q[1] & ~press_q[0];
    assign btn_step   = press_next | press_prev;
    assign auto_tick  = sync2_q[2] && (auto_cnt_q == AUTO_LAST);
    // Any button activity, including a cancelling next+prev pair, suppresses the tick.
    assign take_tick  = auto_tick & ~press_q[0] & ~press_q[1];
    assign ptr_inc    = (pointer_q == PTR_LAST) ? '0 : pointer_q + 1'b1;
    assign ptr_dec    = (pointer_q == '0) ? PTR_LAST : pointer_q - 1'b1;

    always_comb begin
        ptr_d  = pointer_q;
        step_d = 1'b0;
        if (press_next || take_tick) begin
            ptr_d  = ptr_inc;
            step_d = 1'b1;
        end else if (press_prev) begin
            ptr_d  = ptr_dec;
            step_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pointer_q  <= '0;
            step_q     <= 1'b0;
            auto_cnt_q <= '0;
        end else begin
            pointer_q <= ptr_d;
            step_q    <= step_d;
            if (!sync2_q[2] || btn_step || auto_cnt_q == AUTO_LAST) auto_cnt_q <= '0;
            else auto_cnt_q <= auto_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            refresh_q   <= '0;
            digit_idx_q <= DIG_LAST;
        end else if (refresh_q == REF_LAST) begin
            refresh_q   <= '0;
            digit_idx_q <= (digit_idx_q == '0) ? DIG_LAST : digit_idx_q - 1'b1;
        end else begin
            refresh_q <= refresh_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < MSG_DEPTH; i++) buffer_q[i] <= CHAR_W'(i);
        end else if (wr_en && ({1'b0, wr_addr} < DEPTH_W)) begin
            buffer_q[wr_addr] <= wr_data;
        end
    end

    // Digit k shows entry pointer + (NUM_DIGITS-1-k); the sum never reaches 2*MSG_DEPTH.
    always_comb begin
        rd_sum = {1'b0, pointer_q} + OFS_BASE - (AW + 1)'(digit_idx_q);
        rd_idx = (rd_sum >= DEPTH_W) ? rd_sum[AW-1:0] - DEPTH_W[AW-1:0] : rd_sum[AW-1:0];
        digit_onehot = NUM_DIGITS'(1) << digit_idx_q;
        an_d = (refresh_q == '0) ? '1 : ~digit_onehot;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            an_q   <= '1;
            char_q <= '0;
        end else begin
            an_q   <= an_d;
            char_q <= buffer_q[rd_idx];
        end
    end

    assign an         = an_q;
    assign digit_char = char_q;
    assign pointer    = pointer_q;
    assign step       = step_q;

endmodule

// File: tb/tb_message_scroller.sv
// Self-checking bench for message_scroller with short debounce, refresh and auto periods.
module tb_message_scroller;

    logic       clk, reset, btn_next, btn_prev, auto_en, wr_en;
    logic [3:0] wr_addr, wr_data, an, digit_char, pointer;
    logic       step;

    int n_checks, n_fail;
    int model_ptr;
    logic [3:0]  model_buf [16];
    logic [3:0]  exp_q [$];
    logic [15:0] win_q [$];
    logic [7:0]  scan_q [$];

    message_scroller #(
        .NUM_DIGITS(4), .MSG_DEPTH(16), .CHAR_W(4),
        .DEBOUNCE_CYCLES(4), .REFRESH_CYCLES(4), .AUTO_CYCLES(8)
    ) u_dut (
        .clk(clk), .reset(reset), .btn_next(btn_next), .btn_prev(btn_prev),
        .auto_en(auto_en), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .an(an), .digit_char(digit_char), .pointer(pointer), .step(step)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [15:0] model_window();
        logic [15:0] w;
        for (int k = 0; k < 4; k++) w[k*4 +: 4] = model_buf[(model_ptr + 3 - k) % 16];
        return w;
    endfunction

    task automatic model_reset();
        model_ptr = 0;
        for (int i = 0; i < 16; i++) model_buf[i] = 4'(i);
    endtask

    task automatic model_move(input int dir);
        model_ptr = (model_ptr + dir + 16) % 16;
        exp_q.push_back(4'(model_ptr));
    endtask

    // driver: hold buttons 12 cycles, release 12 cycles, counting step pulses
    task automatic press_button(input logic nxt, input logic prv, output int steps, output int wide);
        logic prev_s;
        steps = 0; wide = 0; prev_s = 1'b0;
        btn_next = nxt; btn_prev = prv;
        for (int i = 0; i < 24; i++) begin
            if (i == 12) begin btn_next = 1'b0; btn_prev = 1'b0; end
            @(negedge clk);
            if (step) begin steps++; if (prev_s) wide++; end
            prev_s = step;
        end
    endtask

    // monitor: record the character shown on each lit digit over one full scan
    task automatic capture_window(output logic [15:0] chars, output logic [3:0] seen);
        logic [3:0] onehot;
        chars = '0; seen = '0;
        repeat (20) begin
            @(negedge clk);
            for (int k = 0; k < 4; k++) begin
                onehot = 4'b0001 << k;
                if (an === ~onehot) begin chars[k*4 +: 4] = digit_char; seen[k] = 1'b1; end
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; btn_next = 0; btn_prev = 0; auto_en = 0; wr_en = 0; wr_addr = 0; wr_data = 0;
        model_reset();
        repeat (3) @(negedge clk);
        n_checks++; if (an !== 4'hF) begin n_fail++; $display("FAIL reset_an: got %h expected f", an); end
        n_checks++; if (pointer !== 4'h0) begin n_fail++; $display("FAIL reset_pointer: got %h expected 0", pointer); end
        n_checks++; if (step !== 1'b0) begin n_fail++; $display("FAIL reset_step: got %b expected 0", step); end
        n_checks++; if (digit_char !== 4'h0) begin n_fail++; $display("FAIL reset_char: got %h expected 0", digit_char); end
        reset = 1'b1;
    endtask

    task automatic test_scan();
        logic [3:0] onehot, e_an;
        logic [7:0] e;
        for (int i = 0; i < 16; i++) begin
            onehot = 4'b0001 << (3 - i / 4);
            e_an = (i % 4 == 0) ? 4'hF : ~onehot;
            scan_q.push_back({e_an, model_buf[(model_ptr + i / 4) % 16]});
        end
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            e = scan_q.pop_front();
            n_checks++;
            if (an !== e[7:4]) begin n_fail++; $display("FAIL scan_an[%0d]: got %b expected %b", i, an, e[7:4]); end
            if (e[7:4] != 4'hF) begin
                n_checks++;
                if (digit_char !== e[3:0]) begin
                    n_fail++; $display("FAIL scan_char[%0d]: got %h expected %h", i, digit_char, e[3:0]);
                end
            end
        end
    endtask

    task automatic test_bounce_next();
        int steps, wide, hit;
        logic prev_s;
        steps = 0; wide = 0; hit = -1; prev_s = 1'b0;
        model_move(1);
        for (int i = 0; i < 24; i++) begin
            btn_next = (i == 1 || i >= 12) ? 1'b0 : 1'b1;
            @(negedge clk);
            if (step) begin steps++; if (prev_s) wide++; if (hit < 0) hit = i; end
            prev_s = step;
        end
        n_checks++; if (steps != 1) begin n_fail++; $display("FAIL bounce_steps: got %0d expected 1", steps); end
        n_checks++; if (wide != 0) begin n_fail++; $display("FAIL bounce_step_width: got %0d extra cycles expected 0", wide); end
        n_checks++; if (hit != 2 + 2 + 4) begin n_fail++; $display("FAIL bounce_latency: got %0d expected 8", hit); end
        n_checks++;
        if (pointer !== exp_q[0]) begin n_fail++; $display("FAIL bounce_pointer: got %0d expected %0d", pointer, exp_q[0]); end
        void'(exp_q.pop_front());
    endtask

    task automatic test_prev_wrap();
        int steps, wide;
        logic [15:0] chars, e;
        logic [3:0] seen, p;
        for (int n = 0; n < 2; n++) begin
            model_move(-1);
            press_button(1'b0, 1'b1, steps, wide);
            p = exp_q.pop_front();
            n_checks++; if (steps != 1) begin n_fail++; $display("FAIL prev_steps[%0d]: got %0d expected 1", n, steps); end
            n_checks++; if (pointer !== p) begin n_fail++; $display("FAIL prev_pointer[%0d]: got %0d expected %0d", n, pointer, p); end
        end
        win_q.push_back(model_window());
        capture_window(chars, seen);
        e = win_q.pop_front();
        n_checks++; if (seen !== 4'hF) begin n_fail++; $display("FAIL prev_window_seen: got %b expected 1111", seen); end
        n_checks++; if (chars !== e) begin n_fail++; $display("FAIL prev_window: got %h expected %h", chars, e); end
    endtask

    task automatic test_next_wrap();
        int steps, wide;
        logic [15:0] chars, e;
        logic [3:0] seen, p;
        model_move(-1);
        press_button(1'b0, 1'b1, steps, wide);
        p = exp_q.pop_front();
        n_checks++; if (pointer !== p) begin n_fail++; $display("FAIL to14_pointer: got %0d expected %0d", pointer, p); end
        model_move(1);
        press_button(1'b1, 1'b0, steps, wide);
        p = exp_q.pop_front();
        n_checks++; if (pointer !== p) begin n_fail++; $display("FAIL next15_pointer: got %0d expected %0d", pointer, p); end
        win_q.push_back(model_window());
        capture_window(chars, seen);
        e = win_q.pop_front();
        n_checks++; if (chars !== e) begin n_fail++; $display("FAIL next15_window: got %h expected %h", chars, e); end
        model_move(1);
        press_button(1'b1, 1'b0, steps, wide);
        p = exp_q.pop_front();
        n_checks++; if (pointer !== p) begin n_fail++; $display("FAIL next_wrap_pointer: got %0d expected %0d", pointer, p); end
    endtask

    task automatic test_write();
        logic [15:0] chars, e;
        logic [3:0] seen, last_an, old_c;
        bit found;
        @(negedge clk);
        wr_en = 1'b1; wr_addr = 4'd2; wr_data = 4'hA;
        model_buf[2] = 4'hA;
        @(negedge clk);
        wr_en = 1'b0; wr_addr = 4'd3; wr_data = 4'h9;
        win_q.push_back(model_window());
        capture_window(chars, seen);
        e = win_q.pop_front();
        n_checks++; if (chars !== e) begin n_fail++; $display("FAIL write_window: got %h expected %h", chars, e); end
        n_checks++; if (chars[7:4] !== 4'hA) begin n_fail++; $display("FAIL write_third_digit: got %h expected a", chars[7:4]); end
        // write the entry shown on the leftmost digit while it is lit
        found = 0; last_an = an;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (last_an === 4'hF && an === 4'b0111) found = 1;
            last_an = an;
        end
        n_checks++;
        if (!found) begin
            n_fail++; $display("FAIL collision_wait: got no leftmost slot start expected one within 40 cycles");
        end else begin
            old_c = model_buf[model_ptr];
            wr_en = 1'b1; wr_addr = 4'(model_ptr); wr_data = 4'h5;
            model_buf[model_ptr] = 4'h5;
            @(negedge clk);
            wr_en = 1'b0;
            n_checks++; if (digit_char !== old_c) begin n_fail++; $display("FAIL collision_old: got %h expected %h", digit_char, old_c); end
            @(negedge clk);
            n_checks++; if (digit_char !== 4'h5) begin n_fail++; $display("FAIL collision_new: got %h expected 5", digit_char); end
        end
    endtask

    task automatic test_auto();
        int steps;
        logic [3:0] p;
        steps = 0;
        for (int n = 0; n < 5; n++) model_move(1);
        auto_en = 1'b1;
        for (int i = 0; i < 52; i++) begin
            if (i == 40) auto_en = 1'b0;
            @(negedge clk);
            if (step) steps++;
        end
        for (int n = 0; n < 4; n++) void'(exp_q.pop_front());
        p = exp_q.pop_front();
        n_checks++; if (steps != 5) begin n_fail++; $display("FAIL auto_steps: got %0d expected 5", steps); end
        n_checks++; if (pointer !== p) begin n_fail++; $display("FAIL auto_pointer: got %0d expected %0d", pointer, p); end
    endtask

    task automatic test_tick_collision();
        int steps;
        logic [3:0] p;
        steps = 0;
        model_move(1);
        for (int i = 0; i < 26; i++) begin
            auto_en  = (i < 14);
            btn_next = (i >= 3 && i < 14);
            @(negedge clk);
            if (step) steps++;
        end
        p = exp_q.pop_front();
        n_checks++; if (steps != 1) begin n_fail++; $display("FAIL tick_collision_steps: got %0d expected 1", steps); end
        n_checks++; if (pointer !== p) begin n_fail++; $display("FAIL tick_collision_pointer: got %0d expected %0d", pointer, p); end
    endtask

    task automatic test_both_buttons();
        int steps, wide;
        logic [3:0] p;
        model_move(0);
        press_button(1'b1, 1'b1, steps, wide);
        p = exp_q.pop_front();
        n_checks++; if (steps != 0) begin n_fail++; $display("FAIL both_steps: got %0d expected 0", steps); end
        n_checks++; if (pointer !== p) begin n_fail++; $display("FAIL both_pointer: got %0d expected %0d", pointer, p); end
    endtask

    task automatic test_reset_mid();
        logic [15:0] chars, e;
        logic [3:0] seen;
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        n_checks++; if (an !== 4'hF) begin n_fail++; $display("FAIL midreset_an: got %b expected 1111", an); end
        n_checks++; if (pointer !== 4'h0) begin n_fail++; $display("FAIL midreset_pointer: got %0d expected 0", pointer); end
        n_checks++; if (step !== 1'b0) begin n_fail++; $display("FAIL midreset_step: got %b expected 0", step); end
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        win_q.push_back(model_window());
        capture_window(chars, seen);
        e = win_q.pop_front();
        n_checks++; if (chars !== e) begin n_fail++; $display("FAIL midreset_window: got %h expected %h", chars, e); end
    endtask

    task automatic test_held_through_reset();
        int steps;
        logic [3:0] p;
        steps = 0;
        @(negedge clk);
        reset = 1'b0; btn_next = 1'b1;
        model_reset();
        model_move(1);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 24; i++) begin
            if (i == 12) btn_next = 1'b0;
            @(negedge clk);
            if (step) steps++;
        end
        p = exp_q.pop_front();
        n_checks++; if (steps != 1) begin n_fail++; $display("FAIL held_reset_steps: got %0d expected 1", steps); end
        n_checks++; if (pointer !== p) begin n_fail++; $display("FAIL held_reset_pointer: got %0d expected %0d", pointer, p); end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_scan();
        test_bounce_next();
        test_prev_wrap();
        test_next_wrap();
        test_write();
        test_auto();
        test_tick_collision();
        test_both_buttons();
        test_reset_mid();
        test_held_through_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
